// File: rtl/sdram_pattern_checker_if.sv
// Command/response bus between the pattern checker and an SDRAM controller.
// The checker is the master: it issues commands and consumes read responses.
interface sdram_pattern_checker_if #(
    parameter int ADDR_WIDTH = 24,
    parameter int DATA_WIDTH = 16
);
    logic                    cmd_valid;
    logic                    cmd_ready;
    logic [ADDR_WIDTH-1:0]   cmd_payload_address;
    logic                    cmd_payload_write;
    logic [DATA_WIDTH-1:0]   cmd_payload_data;
    logic [DATA_WIDTH/8-1:0] cmd_payload_mask;
    logic                    rsp_valid;
    logic                    rsp_ready;
    logic [DATA_WIDTH-1:0]   rsp_payload_data;

    modport master (
        output cmd_valid, cmd_payload_address, cmd_payload_write,
               cmd_payload_data, cmd_payload_mask, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_payload_data
    );

    modport slave (
        input  cmd_valid, cmd_payload_address, cmd_payload_write,
               cmd_payload_data, cmd_payload_mask, rsp_ready,
        output cmd_ready, rsp_valid, rsp_payload_data
    );
endinterface

// File: rtl/sdram_pattern_checker.sv
// SDRAM pattern checker: writes an incrementing pattern over a word range,
// reads it back with bounded outstanding reads, and reports mismatches.
module sdram_pattern_checker #(
    parameter int ADDR_WIDTH      = 24,
    parameter int DATA_WIDTH      = 16,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH-1:0] word_count,
    input  logic [DATA_WIDTH-1:0] seed,
    sdram_pattern_checker_if.master io,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [15:0]           error_count,
    output logic [ADDR_WIDTH-1:0] first_err_addr
);
    localparam int OW = $clog2(MAX_OUTSTANDING) + 1;

    typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, FINISH} state_t;

    state_t                state, state_nxt;
    logic [ADDR_WIDTH-1:0] base_r, count_r, cmd_idx, rsp_idx;
    logic [DATA_WIDTH-1:0] seed_r;
    logic [OW-1:0]         outst;
    logic [15:0]           err_nxt;
    logic                  cmd_fire, rd_fire, rsp_fire, last_cmd, mismatch;

    assign cmd_fire = io.cmd_valid && io.cmd_ready;
    assign rd_fire  = cmd_fire && (state == READ);
    assign rsp_fire = io.rsp_valid && io.rsp_ready;
    assign last_cmd = (cmd_idx == count_r - 1'b1);
    assign mismatch = rsp_fire &&
                      (io.rsp_payload_data != seed_r + DATA_WIDTH'(rsp_idx));

    // Next-state logic and bus/status outputs. Command payload is derived
    // from registered state and cmd_idx, which only moves on acceptance, so
    // it stays stable while a command is stalled. In READ the outstanding
    // count can only fall while stalled, so valid cannot drop either.
    always_comb begin
        state_nxt              = state;
        io.cmd_valid           = 1'b0;
        io.cmd_payload_address = base_r + cmd_idx;
        io.cmd_payload_write   = 1'b0;
        io.cmd_payload_data    = '0;
        io.cmd_payload_mask    = '1;
        io.rsp_ready           = 1'b0;
        busy                   = (state != IDLE);
        done                   = 1'b0;
        err_nxt                = error_count;
        if (mismatch && error_count != 16'hFFFF)
            err_nxt = error_count + 16'd1;
        case (state)
            IDLE: begin
                if (start)
                    state_nxt = (word_count == '0) ? FINISH : WRITE;
            end
            WRITE: begin
                io.cmd_valid         = 1'b1;
                io.cmd_payload_write = 1'b1;
                io.cmd_payload_data  = seed_r + DATA_WIDTH'(cmd_idx);
                if (cmd_fire && last_cmd)
                    state_nxt = READ;
            end
            READ: begin
                io.cmd_valid = (outst != OW'(MAX_OUTSTANDING));
                io.rsp_ready = 1'b1;
                if (cmd_fire && last_cmd)
                    state_nxt = DRAIN;
            end
            DRAIN: begin
                io.rsp_ready = 1'b1;
                // All responses may already have arrived while still in READ.
                if (rsp_idx == count_r || (rsp_fire && rsp_idx == count_r - 1'b1))
                    state_nxt = FINISH;
            end
            FINISH: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // Run parameters, index counters, outstanding tracking and result capture.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            base_r         <= '0;
            count_r        <= '0;
            seed_r         <= '0;
            cmd_idx        <= '0;
            rsp_idx        <= '0;
            outst          <= '0;
            error_count    <= '0;
            pass           <= 1'b0;
            first_err_addr <= '0;
        end else if (state == IDLE) begin
            if (start) begin
                base_r         <= base_addr;
                count_r        <= word_count;
                seed_r         <= seed;
                cmd_idx        <= '0;
                rsp_idx        <= '0;
                outst          <= '0;
                error_count    <= '0;
                first_err_addr <= '0;
                // An empty run goes straight to FINISH and trivially passes.
                pass           <= (word_count == '0);
            end
        end else begin
            if (cmd_fire)
                cmd_idx <= last_cmd ? '0 : cmd_idx + 1'b1;
            if (rsp_fire)
                rsp_idx <= rsp_idx + 1'b1;
            case ({rd_fire, rsp_fire})
                2'b10:   outst <= outst + 1'b1;
                2'b01:   outst <= outst - 1'b1;
                default: outst <= outst;
            endcase
            error_count <= err_nxt;
            // error_count saturates and never returns to zero within a run,
            // so zero means no earlier mismatch has been seen.
            if (mismatch && error_count == 16'd0)
                first_err_addr <= base_r + rsp_idx;
            // Result is set on FINISH entry so it is valid alongside done.
            if (state == DRAIN && state_nxt == FINISH)
                pass <= (err_nxt == 16'd0);
        end
    end
endmodule

// File: tb/tb_sdram_pattern_checker.sv
// Bench for sdram_pattern_checker: behavioural memory with latency and
// random back-pressure, command-stream monitor, and per-run result model.
module tb_sdram_pattern_checker;
    localparam int AW = 24;
    localparam int DW = 16;
    localparam int MO = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start;
    logic [AW-1:0] base_addr, word_count;
    logic [DW-1:0] seed;
    logic          busy, done, pass;
    logic [15:0]   error_count;
    logic [AW-1:0] first_err_addr;

    always #5 clk = ~clk;

    sdram_pattern_checker_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) io();

    sdram_pattern_checker #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(MO)) dut (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
        .word_count(word_count), .seed(seed), .io(io), .busy(busy), .done(done),
        .pass(pass), .error_count(error_count), .first_err_addr(first_err_addr)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // memory / run configuration
    int            rsp_lat = 1;
    bit            rand_ready = 0;
    bit            corrupt_en = 0;
    logic [AW-1:0] corrupt_addr = '0;
    logic [DW-1:0] corrupt_val = '0;

    // reference run state
    logic [AW-1:0] r_base, r_n;
    logic [DW-1:0] r_seed;
    int wr_cnt, rd_cnt, rsp_cnt, outst, max_outst, cyc;
    logic [DW-1:0] mem [logic [AW-1:0]];

    typedef struct { int due; logic [DW-1:0] data; } rsp_t;
    rsp_t rq[$];

    bit              stall;
    logic [AW-1:0]   p_addr;
    logic            p_write;
    logic [DW-1:0]   p_data;

    // Memory responder and command monitor: inputs change at the falling
    // edge, handshakes are evaluated just after, ahead of the rising edge.
    initial begin
        logic [AW-1:0] ea;
        io.cmd_ready = 1'b0;
        io.rsp_valid = 1'b0;
        io.rsp_payload_data = '0;
        stall = 0;
        cyc = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!reset) begin
                rq.delete();
                io.cmd_ready = 1'b0;
                io.rsp_valid = 1'b0;
                stall = 0;
                continue;
            end
            io.cmd_ready = rand_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
            io.rsp_valid = (rq.size() > 0) && (rq[0].due <= cyc);
            io.rsp_payload_data = io.rsp_valid ? rq[0].data : DW'($urandom);
            #1;
            if (stall) begin
                chk("hold_valid", 64'(io.cmd_valid), 64'(1'b1));
                chk("hold_addr", 64'(io.cmd_payload_address), 64'(p_addr));
                chk("hold_write", 64'(io.cmd_payload_write), 64'(p_write));
                chk("hold_data", 64'(io.cmd_payload_data), 64'(p_data));
            end
            if (io.cmd_valid && io.cmd_ready) begin
                if (io.cmd_payload_write) begin
                    ea = r_base + AW'(wr_cnt);
                    chk("wr_phase", 64'(rd_cnt), 64'(0));
                    chk("wr_addr", 64'(io.cmd_payload_address), 64'(ea));
                    chk("wr_data", 64'(io.cmd_payload_data), 64'(r_seed + DW'(wr_cnt)));
                    chk("wr_mask", 64'(io.cmd_payload_mask), 64'({(DW/8){1'b1}}));
                    mem[io.cmd_payload_address] =
                        (corrupt_en && io.cmd_payload_address == corrupt_addr)
                        ? corrupt_val : io.cmd_payload_data;
                    wr_cnt++;
                end else begin
                    ea = r_base + AW'(rd_cnt);
                    chk("rd_phase", 64'(wr_cnt), 64'(r_n));
                    chk("rd_addr", 64'(io.cmd_payload_address), 64'(ea));
                    chk("rd_data", 64'(io.cmd_payload_data), 64'(0));
                    chk("rd_mask", 64'(io.cmd_payload_mask), 64'({(DW/8){1'b1}}));
                    rq.push_back('{due: cyc + rsp_lat,
                                   data: mem.exists(io.cmd_payload_address)
                                         ? mem[io.cmd_payload_address] : 16'hDEAD});
                    rd_cnt++;
                    outst++;
                    if (outst > max_outst) max_outst = outst;
                    chk("outstanding_limit", 64'(outst <= MO), 64'(1'b1));
                end
            end
            if (io.rsp_valid && io.rsp_ready) begin
                rq.delete(0);
                rsp_cnt++;
                outst--;
            end
            stall   = io.cmd_valid && !io.cmd_ready;
            p_addr  = io.cmd_payload_address;
            p_write = io.cmd_payload_write;
            p_data  = io.cmd_payload_data;
        end
    end

    task automatic start_run(input logic [AW-1:0] b, input logic [AW-1:0] n,
                             input logic [DW-1:0] s);
        @(negedge clk);
        r_base = b; r_n = n; r_seed = s;
        wr_cnt = 0; rd_cnt = 0; rsp_cnt = 0; outst = 0; max_outst = 0;
        mem.delete();
        base_addr = b; word_count = n; seed = s;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done();
        int k = 0;
        while (done !== 1'b1 && k < 3000) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk("done_seen", 64'(done), 64'(1'b1));
    endtask

    // Expected result from the memory contents the run should have produced:
    // word j holds pattern j unless it landed on the corrupted address.
    task automatic expect_result();
        int            e = 0;
        logic [AW-1:0] f = '0;
        logic [AW-1:0] a;
        logic [DW-1:0] pat, st;
        bit            seen = 0;
        for (int j = 0; j < int'(r_n); j++) begin
            a   = r_base + AW'(j);
            pat = r_seed + DW'(j);
            st  = (corrupt_en && a == corrupt_addr) ? corrupt_val : pat;
            if (st != pat) begin
                e++;
                if (!seen) begin f = a; seen = 1; end
            end
        end
        chk("res_pass", 64'(pass), 64'(e == 0));
        chk("res_err_count", 64'(error_count), 64'(e));
        chk("res_first_err", 64'(first_err_addr), 64'(f));
        chk("res_busy_finish", 64'(busy), 64'(1'b1));
        chk("res_writes", 64'(wr_cnt), 64'(r_n));
        chk("res_reads", 64'(rd_cnt), 64'(r_n));
        chk("res_rsps", 64'(rsp_cnt), 64'(r_n));
        @(posedge clk);
        #1;
        chk("done_one_cycle", 64'(done), 64'(1'b0));
        chk("idle_busy", 64'(busy), 64'(1'b0));
        chk("hold_pass", 64'(pass), 64'(e == 0));
        chk("hold_err_count", 64'(error_count), 64'(e));
    endtask

    task automatic full_run(input logic [AW-1:0] b, input logic [AW-1:0] n,
                            input logic [DW-1:0] s, input int lat, input bit rr,
                            input bit cen, input logic [AW-1:0] ca,
                            input logic [DW-1:0] cv);
        rsp_lat = lat; rand_ready = rr;
        corrupt_en = cen; corrupt_addr = ca; corrupt_val = cv;
        start_run(b, n, s);
        chk("busy_after_start", 64'(busy), 64'(1'b1));
        wait_done();
        expect_result();
    endtask

    initial begin
        logic [AW-1:0] rb, rn;
        start = 1'b0; base_addr = '0; word_count = '0; seed = '0;
        r_base = '0; r_n = '0; r_seed = '0;
        wr_cnt = 0; rd_cnt = 0; rsp_cnt = 0; outst = 0; max_outst = 0;

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_cmd_valid", 64'(io.cmd_valid), 64'(1'b0));
        chk("rst_rsp_ready", 64'(io.rsp_ready), 64'(1'b0));
        chk("rst_busy", 64'(busy), 64'(1'b0));
        chk("rst_done", 64'(done), 64'(1'b0));
        chk("rst_pass", 64'(pass), 64'(1'b0));
        chk("rst_err_count", 64'(error_count), 64'(0));
        chk("rst_first_err", 64'(first_err_addr), 64'(0));
        chk("rst_cmd_addr", 64'(io.cmd_payload_address), 64'(0));
        chk("rst_cmd_data", 64'(io.cmd_payload_data), 64'(0));
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // ideal memory, basic run
        full_run(24'h000100, 24'd4, 16'h1234, 1, 0, 0, '0, '0);
        chk("mem_0x100", 64'(mem[24'h000100]), 64'(16'h1234));
        chk("mem_0x103", 64'(mem[24'h000103]), 64'(16'h1237));

        // corrupted word
        full_run(24'h000100, 24'd4, 16'h1234, 1, 0, 1, 24'h000102, 16'h0000);
        chk("corrupt_first_err", 64'(first_err_addr), 64'(24'h000102));

        // address wrap-around
        full_run(24'hFFFFFE, 24'd4, 16'hABCD, 1, 0, 0, '0, '0);
        chk("wrap_mem_0", 64'(mem[24'h000000]), 64'(16'hABCF));
        chk("wrap_mem_1", 64'(mem[24'h000001]), 64'(16'hABD0));

        // empty run: done in the cycle right after start is taken
        corrupt_en = 0;
        start_run(24'h000050, 24'd0, 16'h0001);
        chk("zero_done_next_cycle", 64'(done), 64'(1'b1));
        expect_result();

        // long latency, random back-pressure: outstanding window must fill
        full_run(24'h000400, 24'd20, 16'h5A5A, 30, 1, 0, '0, '0);
        chk("max_outstanding_reached", 64'(max_outst), 64'(MO));

        // reset during READ aborts the run
        rsp_lat = 5; rand_ready = 0; corrupt_en = 0;
        start_run(24'h000800, 24'd16, 16'h0F0F);
        for (int k = 0; k < 200 && rd_cnt < 3; k++) @(negedge clk);
        chk("abort_in_read", 64'(rd_cnt >= 3), 64'(1'b1));
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        chk("abort_cmd_valid", 64'(io.cmd_valid), 64'(1'b0));
        chk("abort_rsp_ready", 64'(io.rsp_ready), 64'(1'b0));
        chk("abort_busy", 64'(busy), 64'(1'b0));
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            chk("abort_no_done", 64'(done), 64'(1'b0));
        end
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_still_idle", 64'(done | busy), 64'(1'b0));
        full_run(24'h000800, 24'd16, 16'h0F0F, 5, 0, 0, '0, '0);

        // randomized runs
        for (int r = 0; r < 6; r++) begin
            rb = AW'($urandom);
            rn = AW'($urandom_range(1, 24));
            full_run(rb, rn, DW'($urandom), $urandom_range(1, 30),
                     bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
                     rb + AW'($urandom_range(0, int'(rn) - 1)), DW'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
